fl_in_port: RTL



---
 rtl/fl_in_port.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fl_in_port.sv
// Multi-channel buffered input port: per-channel FIFOs feeding the core's addr_in/req_in/io_in read port.
// Optional macro FL_I2F_EN converts signed NBINT integer samples to float words on entry.
module fl_in_port #(
    parameter int unsigned NBMANT = 16,
    parameter int unsigned NBEXPO = 6,
    parameter int unsigned NUIOIN = 8,
    parameter int unsigned FDEPTH = 16,
    parameter int unsigned NBINT  = 24
) (
    input  logic                                        clk,
    input  logic                                        rst,
`ifdef FL_I2F_EN
    input  logic [NUIOIN*NBINT-1:0]                     ch_data,
`else
    input  logic [NUIOIN*(NBMANT+NBEXPO+1)-1:0]         ch_data,
`endif
    input  logic [NUIOIN-1:0]                           ch_valid,
    output logic [NUIOIN-1:0]                           ch_ready,
    input  logic [(NUIOIN > 1 ? $clog2(NUIOIN) : 1)-1:0] addr_in,
    input  logic                                        req_in,
    output logic [NBMANT+NBEXPO:0]                      io_in,
    output logic [NUIOIN-1:0]                           ch_avail,
    output logic [NUIOIN-1:0]                           underrun,
    input  logic [NUIOIN-1:0]                           clr_underrun
);

    localparam int unsigned W  = NBMANT + NBEXPO + 1;
    localparam int unsigned AW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int unsigned PW = $clog2(FDEPTH);
    localparam int unsigned CW = PW + 1;
`ifdef FL_I2F_EN
    localparam int unsigned IW = NBINT;

    // Signed integer to float: magnitude normalised so mantissa msb is set.
    function automatic logic [W-1:0] i2f(input logic [NBINT-1:0] x);
        logic [NBINT-1:0]        m;
        logic [NBINT+NBMANT-1:0] ext;
        logic [NBEXPO-1:0]       e;
        int                      p;
        m = x[NBINT-1] ? (~x + 1'b1) : x;
        p = 0;
        for (int i = 0; i < int'(NBINT); i++) begin
            if (m[i]) p = i;
        end
        ext = {{NBMANT{1'b0}}, m};
        if (p >= int'(NBMANT) - 1) ext = ext >> (p - int'(NBMANT) + 1);
        else                       ext = ext << (int'(NBMANT) - 1 - p);
        e = NBEXPO'(p - int'(NBMANT) + 1);
        if (m == '0) return {1'b0, 1'b1, {(NBEXPO-1){1'b0}}, {NBMANT{1'b0}}};
        return {x[NBINT-1], e, ext[NBMANT-1:0]};
    endfunction
`else
    localparam int unsigned IW = W;
    logic [31:0] unused_nbint;
    assign unused_nbint = 32'(NBINT);
`endif

    logic           addr_ok_c;
    logic [W-1:0]   head_c [NUIOIN];
    logic [W-1:0]   hold_c [NUIOIN];

    assign addr_ok_c = 32'(addr_in) < NUIOIN;

    for (genvar k = 0; k < int'(NUIOIN); k++) begin : g_ch
        logic [W-1:0]  mem_q [FDEPTH];
        logic [W-1:0]  wr_word_c;
        logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [W-1:0]  hold_q, hold_d;
        logic          und_q, und_d;
        logic          sel_c, push_c, pop_c;

`ifdef FL_I2F_EN
        assign wr_word_c = i2f(ch_data[k*IW +: IW]);
`else
        assign wr_word_c = ch_data[k*IW +: IW];
`endif

        // Pop only a non-empty FIFO; a read of an empty one raises the sticky flag.
        always_comb begin
            sel_c  = req_in & addr_ok_c & (addr_in == AW'(k));
            push_c = ch_valid[k] & ch_ready[k];
            pop_c  = sel_c & (cnt_q != '0);
            wr_d   = wr_q;
            rd_d   = rd_q;
            cnt_d  = cnt_q;
            hold_d = hold_q;
            if (push_c) wr_d = wr_q + 1'b1;
            if (pop_c) begin
                rd_d   = rd_q + 1'b1;
                hold_d = mem_q[rd_q];
            end
            case ({push_c, pop_c})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            und_d = (und_q & ~clr_underrun[k]) | (sel_c & (cnt_q == '0));
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_q   <= '0;
                rd_q   <= '0;
                cnt_q  <= '0;
                hold_q <= '0;
                und_q  <= 1'b0;
            end else begin
                wr_q   <= wr_d;
                rd_q   <= rd_d;
                cnt_q  <= cnt_d;
                hold_q <= hold_d;
                und_q  <= und_d;
            end
        end

        // Storage is not reset; push_c is already blocked while rst is high.
        always_ff @(posedge clk) begin
            if (push_c) mem_q[wr_q] <= wr_word_c;
        end

        assign ch_ready[k] = ~rst & (cnt_q != CW'(FDEPTH));
        assign ch_avail[k] = (cnt_q != '0);
        assign underrun[k] = und_q;
        assign head_c[k]   = mem_q[rd_q];
        assign hold_c[k]   = hold_q;
    end

    // Show-ahead read: head when available, otherwise the last word popped.
    always_comb begin
        io_in = '0;
        if (addr_ok_c) io_in = ch_avail[addr_in] ? head_c[addr_in] : hold_c[addr_in];
    end

endmodule
